// File: rtl/normalize_pipe.sv
// normalize_pipe: three-stage per-channel offset/scale/shift/gain pipeline with a shared valid chain.
// Define NORMALIZE_SAT_EN to clamp the stage-2 result into the output range and raise sat_flag.
module normalize_pipe #(
  parameter int          N_CH   = 2,
  parameter int          IN_W   = 32,
  parameter int          OUT_W  = 18,
  parameter int          OFFSET = 262143,
  parameter int unsigned SCALE  = 10000,
  parameter int unsigned SHIFT  = 19,
  parameter int unsigned GAIN   = 107374
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [N_CH*IN_W-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_CH*OUT_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_cnt,
  output logic                  sat_flag,
  input  logic                  sat_clr
);

  localparam int SUM_W  = IN_W + 1;
  localparam int PROD_W = SUM_W + 33;
  localparam int GP_W   = OUT_W + 32;
  localparam int FRAC_W = 18;

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // Every stage moves together whenever the output slot is empty or being drained.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic                     s1_valid;
  logic                     s2_valid;
  logic signed [PROD_W-1:0] prod_c  [N_CH];
  logic signed [PROD_W-1:0] s1_prod [N_CH];
  logic [OUT_W-1:0]         div_c   [N_CH];
  logic [OUT_W-1:0]         s2_div  [N_CH];
  logic [N_CH-1:0]          sat_c;
  logic [N_CH*OUT_W-1:0]    out_c;
  logic                     sat_set;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic signed [IN_W-1:0]  x;
    logic signed [SUM_W-1:0] sum;
    logic [OUT_W-1:0]        ch_div;
    logic                    ch_sat;

    assign x         = in_data[i*IN_W +: IN_W];
    assign sum       = SUM_W'(x) + SUM_W'(OFFSET);
    assign prod_c[i] = PROD_W'(sum) * PROD_W'($signed({1'b0, SCALE}));

`ifdef NORMALIZE_SAT_EN
    localparam logic signed [PROD_W-1:0] DIV_MAX = PROD_W'({OUT_W{1'b1}});
    logic signed [PROD_W-1:0] shifted;
    assign shifted = s1_prod[i] >>> SHIFT;

    always_comb begin
      ch_div = shifted[OUT_W-1:0];
      ch_sat = 1'b0;
      if (shifted < 0) begin
        ch_div = '0;
        ch_sat = 1'b1;
      end else if (shifted > DIV_MAX) begin
        ch_div = '1;
        ch_sat = 1'b1;
      end
    end
`else
    // Without clamping the result simply wraps into the output width.
    assign ch_div = OUT_W'(s1_prod[i] >>> SHIFT);
    assign ch_sat = 1'b0;
`endif

    assign div_c[i] = ch_div;
    assign sat_c[i] = ch_sat;
    assign out_c[i*OUT_W +: OUT_W] = OUT_W'((GP_W'(s2_div[i]) * GP_W'(GAIN)) >> FRAC_W);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        s1_prod[i] <= '0;
        s2_div[i]  <= '0;
      end
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      out_data  <= out_c;
      for (int i = 0; i < N_CH; i++) begin
        s1_prod[i] <= prod_c[i];
        s2_div[i]  <= div_c[i];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_cnt <= '0;
    end else if (out_valid && out_ready) begin
      out_cnt <= out_cnt + 16'd1;
    end
  end

  // Saturation is only recorded when the flagged vector actually moves into stage 2.
  assign sat_set = advance && s1_valid && (|sat_c);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sat_flag <= 1'b0;
    end else if (sat_set) begin
      sat_flag <= 1'b1;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_normalize_pipe.sv
// tb_normalize_pipe: directed and randomized checks of normalize_pipe against an arithmetic reference.
// Expectations follow NORMALIZE_SAT_EN the same way the design build does.
module tb_normalize_pipe;

  localparam int    N_CH    = 2;
  localparam int    IN_W    = 32;
  localparam int    OUT_W   = 18;
  localparam longint OFFSET = 262143;
  localparam longint SCALE  = 10000;
  localparam int    SHIFT   = 19;
  localparam longint GAIN   = 107374;
  localparam longint DIV_MAX = (64'sd1 <<< OUT_W) - 1;
`ifdef NORMALIZE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic                  ap_clk;
  logic                  ap_rst_n;
  logic [N_CH*IN_W-1:0]  in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [N_CH*OUT_W-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           out_cnt;
  logic                  sat_flag;
  logic                  sat_clr;

  normalize_pipe dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
  );

  // Clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N_CH*OUT_W-1:0] exp_q[$];
  logic [15:0]           exp_cnt = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference model: plain 64-bit arithmetic from the normalization rules.
  function automatic logic [OUT_W-1:0] model_ch(input logic [IN_W-1:0] x);
    longint s, p, d, o;
    s = longint'($signed(x)) + OFFSET;
    p = s * SCALE;
    d = p >>> SHIFT;
`ifdef NORMALIZE_SAT_EN
    if (d < 0) d = 0;
    else if (d > DIV_MAX) d = DIV_MAX;
`else
    d = d & DIV_MAX;
`endif
    o = (d * GAIN) >>> 18;
    return o[OUT_W-1:0];
  endfunction

  function automatic logic [N_CH*OUT_W-1:0] model_vec(input logic [N_CH*IN_W-1:0] v);
    logic [N_CH*OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) r[i*OUT_W +: OUT_W] = model_ch(v[i*IN_W +: IN_W]);
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rand_sample();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return IN_W'(-262143 + int'($urandom_range(0, 8)) - 4);
      2:       return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return IN_W'(int'($urandom_range(0, 600000)) - 300000);
    endcase
  endfunction

  function automatic logic [N_CH*IN_W-1:0] rand_vec();
    logic [N_CH*IN_W-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i*IN_W +: IN_W] = rand_sample();
    return v;
  endfunction

  // Scoreboard: sampled on the falling edge, when inputs for the next rising edge are settled.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      check("out_cnt_track", 64'(out_cnt), 64'(exp_cnt));
      if (in_valid && in_ready) exp_q.push_back(model_vec(in_data));
      if (out_valid && out_ready) begin
        check("out_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) check("out_data_order", 64'(out_data), 64'(exp_q.pop_front()));
        exp_cnt++;
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic pulse_reset();
    ap_rst_n = 1'b0;
    step();
    ap_rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [N_CH*IN_W-1:0]  s [5];
    logic [N_CH*OUT_W-1:0] hold_exp;

    ap_rst_n  = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_cnt",   64'(out_cnt),   64'(0));
    check("rst_sat_flag",  64'(sat_flag),  64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_data",  64'(out_data),  64'(0));
    step();
    step();
    ap_rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Zero input: three-cycle latency and known output value.
    in_data  = '0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_c1_valid", 64'(out_valid), 64'(0));
    step();
    check("lat_c2_valid", 64'(out_valid), 64'(0));
    step();
    check("lat_c3_valid", 64'(out_valid), 64'(1));
    check("zero_out_data", 64'(out_data), 64'({18'd2047, 18'd2047}));
    step();
    check("zero_out_cnt", 64'(out_cnt), 64'(1));

    // Slightly negative sum on ch0.
    in_data  = {32'd0, 32'hFFFB_FFFF};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("neg_ch0_out", 64'(out_data[0 +: OUT_W]), SAT_EN ? 64'(0) : 64'(107373));
    check("neg_sat_flag", 64'(sat_flag), 64'(SAT_EN));
    step();

    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_clr_clears", 64'(sat_flag), 64'(0));

    // Large positive ch1; clear requested in the same cycle the saturation lands.
    in_data  = {32'h7FFF_FFFF, 32'd0};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    sat_clr  = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_set_wins", 64'(sat_flag), 64'(SAT_EN));
    step();
    check("big_ch1_out", 64'(out_data[OUT_W +: OUT_W]),
          SAT_EN ? 64'(107373) : 64'(model_ch(32'h7FFF_FFFF)));
    step();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_clr_again", 64'(sat_flag), 64'(0));

    // Back-to-back inputs against a stalled output.
    pulse_reset();
    for (int k = 0; k < 5; k++) s[k] = rand_vec();
    hold_exp  = model_vec(s[0]);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data  = s[k];
      in_valid = 1'b1;
      step();
    end
    in_data = s[3];
    check("stall_out_valid", 64'(out_valid), 64'(1));
    check("stall_in_ready",  64'(in_ready),  64'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_hold_data",  64'(out_data), 64'(hold_exp));
      check("stall_hold_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    step();
    in_data = s[4];
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("b2b_out_cnt", 64'(out_cnt), 64'(5));
    check("b2b_drained", 64'(exp_q.size()), 64'(0));

    // Reset with three samples in flight.
    for (int k = 0; k < 3; k++) begin
      in_data  = rand_vec();
      in_valid = 1'b1;
      step();
    end
    ap_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_cnt",   64'(out_cnt),   64'(0));
    check("midrst_in_ready",  64'(in_ready),  64'(1));
    in_valid = 1'b0;
    step();
    step();
    ap_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("no_stale_out", 64'(out_valid), 64'(0));
    end

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      in_data   = rand_vec();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    check("rand_idle", 64'(out_valid), 64'(0));

    // Counter wrap.
    pulse_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 65535; k++) begin
      in_data = rand_vec();
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("cnt_at_max", 64'(out_cnt), 64'(65535));
    in_data  = rand_vec();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("cnt_wrapped", 64'(out_cnt), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
